wb_sram_slave: RTL
==================

# wb_sram_slave

Wishbone B3 responder: a 32-bit on-chip SRAM slave hung on one slave port of the system bus interconnect. Serves classic single cycles with a configurable number of wait states and, optionally, linear incrementing bursts (CTI 010) at one beat per clock. Byte-lane writes follow `sel`. It is the target-side counterpart to the bus masters that drive the interconnect.

## Interface

Parameters:
- `adr_width`, default 10: word-address bits. Memory is 2^adr_width x 32.
- `wait_states`, default 1: idle clocks inserted before the first ack of every cycle. Range 0..15.

Ports:
- `sys_clk`, in, 1: single clock. All logic is on the rising edge.
- `sys_rst`, in, 1: reset. Asynchronous assert, active-low; 0 means reset.
- `wb_adr_i`, in, 32: byte address. The word index is `wb_adr_i[adr_width+1:2]`; higher bits are ignored because the interconnect has already decoded them.
- `wb_dat_i`, in, 32: write data.
- `wb_dat_o`, out, 32: read data.
- `wb_cti_i`, in, 3: cycle type. 000 = classic, 001 = constant address, 010 = incrementing, 111 = end of burst.
- `wb_sel_i`, in, 4: byte lane enables. Bit n maps to `dat[8n+7:8n]`.
- `wb_we_i`, in, 1: write enable.
- `wb_cyc_i`, in, 1: cycle valid.
- `wb_stb_i`, in, 1: strobe.
- `wb_ack_o`, out, 1: acknowledge.

## Operation

- FSM states:
  - IDLE
  - WAIT: counts `wait_states` clocks.
  - ACK: one classic beat.
  - BURST: streaming beats.
- Request detection: a request is `cyc & stb` sampled high in IDLE.
  - With `wait_states`=0 the FSM goes directly to ACK (or to BURST when `cti`=010); otherwise it goes to WAIT.
  - The word address is latched into `burst_adr` on entry.
- ACK state: `wb_ack_o` is high for one clock, then the FSM returns to IDLE.
  - Classic, constant-address (001) and end-of-burst (111) cycles therefore cost at least 2 clocks, and the master sees at most one ack per request.
- BURST state (`cti`=010 at request):
  - Ack is high every clock while `cyc & stb`.
  - `burst_adr` increments on each ack, wrapping modulo 2^adr_width.
  - An ack beat carrying `cti`=111 is the last beat; the FSM returns to IDLE.
- Ack gating: `wb_ack_o` = `ack_r & wb_cyc_i & wb_stb_i`. No ack is ever issued while `stb` is low.
- Read path:
  - Memory is read synchronously.
  - The read address is `wb_adr_i` in IDLE/WAIT and `burst_adr+1` on an acked BURST beat (prefetch), so `wb_dat_o` is valid on every ack clock.
  - `wb_dat_o` holds its last value between acks.
- Write path:
  - Data is committed at the rising edge that ends an ack clock.
  - Classic cycles use `wb_adr_i`; bursts use `burst_adr`.
  - Only lanes with `sel`=1 are written; `sel`=0000 writes nothing but still acks.
- Abort: `cyc` low in WAIT, ACK or BURST returns the FSM to IDLE next clock. No write occurs for the un-acked beat.
- `stb` low inside BURST (`cyc` high): the FSM holds BURST with `burst_adr` frozen (master wait state); beats resume when `stb` returns.
- Changes of `we` inside a burst are honoured per beat.

## Timing

- Reset: state IDLE, `wb_ack_o`=0, `wb_dat_o`=0, wait counter 0, `burst_adr`=0. Memory contents are undefined and not cleared.
- Reset mid-cycle: outputs go to reset values immediately (asynchronous). After deassertion, IDLE is entered on the next edge.
- First-ack latency from the edge that samples `cyc & stb`: `wait_states`+1 clocks.
- Classic throughput: 1 beat per (`wait_states`+2) clocks.
- Burst throughput: 1 beat per clock after the first.
- Back-to-back bursts: at least 1 IDLE clock between them.

## Configuration

- `WB_SRAM_BURST_EN` defined: BURST state and address prefetch are compiled in; `cti`=010 streams as described above.
- `WB_SRAM_BURST_EN` undefined: every `cti` value is handled as classic. Each beat pays `wait_states`+2 clocks. `burst_adr` and the prefetch mux are removed.

## Test plan

- Reset, wait_states=1: pull `sys_rst` low mid-cycle -> `wb_ack_o`=0 and `wb_dat_o`=0 the same clock; the next request acks 2 clocks after it is sampled.
- Classic write then read, wait_states=1: write 0xDEADBEEF to byte address 0x10 with sel=1111, then read 0x10 -> ack 2 clocks after the request each time; read returns 0xDEADBEEF; ack is never high on 2 consecutive clocks.
- Byte lanes: write 0x11223344 to 0x20 with sel=0101 over prior 0xFFFFFFFF -> read returns 0xFF22FF44.
- Burst read (BURST_EN, wait_states=0), words 0..3 preloaded 0xA0..0xA3: cti 010,010,010,111 from address 0 -> ack on 4 consecutive clocks with data 0xA0,0xA1,0xA2,0xA3; ack low the following clock.
- Burst wrap and master stall, adr_width=4: burst from word 15 with `stb` low for 2 clocks after beat 1 -> beat 2 returns word 0; ack stays low while `stb` is low.
- Abort: drop `cyc` during WAIT of a write to 0x30 (wait_states=3) -> no ack; a later read of 0x30 returns the old value.

Source files
------------

// File: rtl/wb_sram_slave.sv
// rtl/wb_sram_slave.sv - Wishbone B3 32-bit SRAM slave with wait states and byte lanes
// Define WB_SRAM_BURST_EN to compile in CTI 010 incrementing bursts with read prefetch.
module wb_sram_slave #(
   parameter int adr_width   = 10,
   parameter int wait_states = 1
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [2:0]  wb_cti_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic        wb_ack_o
);

   typedef enum logic [1:0] {IDLE, WAIT, ACK, BURST} state_t;

   localparam logic [3:0] ws_last  = (wait_states > 0) ? 4'(wait_states - 1) : 4'd0;
   localparam logic [2:0] cti_incr = 3'b010;
   localparam logic [2:0] cti_eob  = 3'b111;

   state_t               state, state_nxt;
   logic [3:0]           wait_cnt, wait_cnt_nxt;
   logic                 req, ack_r, load_rd, rd_en, wr_en, is_burst_req;
   logic [adr_width-1:0] word_adr, rd_adr, wr_adr;
   logic [31:0]          mem [2**adr_width];
   logic                 unused_bits;

   assign word_adr = wb_adr_i[adr_width+1:2];
   assign req      = wb_cyc_i & wb_stb_i;
   assign ack_r    = (state == ACK) || (state == BURST);
   assign wb_ack_o = ack_r & wb_cyc_i & wb_stb_i;
   assign wr_en    = wb_ack_o & wb_we_i;

`ifdef WB_SRAM_BURST_EN
   logic [adr_width-1:0] burst_adr, burst_adr_nxt;
   logic                 burst_r, burst_r_nxt;

   // cti is only trusted on the sampling edge; later WAIT exits use the latched flag
   assign is_burst_req = (state == IDLE) ? (wb_cti_i == cti_incr) : burst_r;
   assign rd_adr       = (state == BURST) ? burst_adr + 1'b1 : word_adr;
   assign wr_adr       = (state == BURST) ? burst_adr : word_adr;
   assign rd_en        = load_rd | ((state == BURST) & wb_ack_o);
   assign unused_bits  = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0]};
`else
   assign is_burst_req = 1'b0;
   assign rd_adr       = word_adr;
   assign wr_adr       = word_adr;
   assign rd_en        = load_rd;
   assign unused_bits  = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0], wb_cti_i};
`endif

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      load_rd      = 1'b0;
`ifdef WB_SRAM_BURST_EN
      burst_adr_nxt = burst_adr;
      burst_r_nxt   = burst_r;
`endif
      case (state)
         IDLE: begin
            if (req) begin
               wait_cnt_nxt = '0;
`ifdef WB_SRAM_BURST_EN
               burst_adr_nxt = word_adr;
               burst_r_nxt   = is_burst_req;
`endif
               if (wait_states == 0) begin
                  load_rd   = 1'b1;
                  state_nxt = is_burst_req ? BURST : ACK;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (!wb_cyc_i) begin
               state_nxt = IDLE;
            end else if (wait_cnt == ws_last) begin
               load_rd   = 1'b1;
               state_nxt = is_burst_req ? BURST : ACK;
            end else begin
               wait_cnt_nxt = wait_cnt + 4'd1;
            end
         end
         ACK: state_nxt = IDLE;
`ifdef WB_SRAM_BURST_EN
         BURST: begin
            // stb low with cyc high is a master wait state: hold address
            if (!wb_cyc_i) begin
               state_nxt = IDLE;
            end else if (wb_stb_i) begin
               burst_adr_nxt = burst_adr + 1'b1;
               if (wb_cti_i == cti_eob) state_nxt = IDLE;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
         wb_dat_o <= '0;
`ifdef WB_SRAM_BURST_EN
         burst_adr <= '0;
         burst_r   <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
`ifdef WB_SRAM_BURST_EN
         burst_adr <= burst_adr_nxt;
         burst_r   <= burst_r_nxt;
`endif
         if (rd_en) wb_dat_o <= mem[rd_adr];
      end
   end

   always_ff @(posedge sys_clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wb_sel_i[b]) mem[wr_adr][8*b +: 8] <= wb_dat_i[8*b +: 8];
         end
      end
   end

endmodule
